run_monitor: RTL and testbench
==============================

# run_monitor

Parametrised, synthesizable run controller and write monitor that sits beside the processor `top` in simulation and FPGA bring-up. It sequences the processor reset and counts cycles. It watches the data-memory write port (`memwrite`, `dataadr`, `writedata`) and declares pass, fail or timeout. It replaces hand-written reset/clock stimulus and waveform inspection with a registered verdict and a write history.

## Interface
Parameters:
- `DATA_W`, 32, width of address and data buses
- `CNT_W`, 16, width of cycle and write counters
- `RESET_CYCLES`, 2, cycles `cpu_reset` stays high after `reset` deasserts (0 allowed)
- `TIMEOUT`, 1000, RUN cycles before FAIL (≥1)
- `PASS_ADR`, 84, address whose write decides the verdict
- `PASS_DATA`, 7, data value that means pass
- `LOG_DEPTH`, 8, write-log entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_reset`  out  1  reset driven to the processor
- `memwrite`  in  1  processor write strobe
- `dataadr`  in  DATA_W  write address
- `writedata`  in  DATA_W  write data
- `done`  out  1  verdict reached, sticky
- `pass`  out  1  verdict is pass, sticky
- `fail`  out  1  verdict is fail or timeout, sticky
- `timeout`  out  1  fail was caused by timeout
- `cycle_count`  out  CNT_W  RUN cycles elapsed
- `write_count`  out  CNT_W  writes seen in RUN
- `last_adr`, `last_data`  out  DATA_W  most recent RUN write
- `log_idx`  in  $clog2(LOG_DEPTH)  log read index (0 = newest)
- `log_adr`, `log_data`  out  DATA_W  log entry at `log_idx`

## Operation
- States: HOLD, RUN, PASS, FAIL.
- `reset`=1 puts the block in HOLD on the next edge and clears all counters, flags and the log. This applies at any time, including mid-RUN and in terminal states.
- HOLD: `cpu_reset`=1. A hold counter counts RESET_CYCLES cycles after `reset` falls, then the block goes to RUN. With RESET_CYCLES=0 it enters RUN on the first edge with `reset`=0.
- RUN: `cpu_reset`=0. `cycle_count` increments each cycle.
- Write in RUN (`memwrite`=1):
  - `write_count` increments; `last_adr`/`last_data` update; the write is logged.
  - `dataadr`==PASS_ADR and `writedata`==PASS_DATA → PASS.
  - `dataadr`==PASS_ADR with any other data → FAIL.
- If `cycle_count` reaches TIMEOUT-1 with no decision → FAIL with `timeout`=1. A deciding write on that same cycle takes priority over the timeout.
- PASS/FAIL:
  - Terminal until `reset`.
  - `cpu_reset`=1 to freeze the processor.
  - Counters freeze; `memwrite` is ignored.
- Writes during HOLD are ignored.
- Both counters saturate at all-ones and never wrap.

## Timing
- All outputs are registered except `log_adr`/`log_data`, which are a combinational read of registered storage.
- Reset values:
  - `cpu_reset`=1
  - `done`=`pass`=`fail`=`timeout`=0
  - counters, `last_*` and log entries = 0
- Verdict latency: `done` and `pass`/`fail` assert together on the edge that samples the deciding write, visible the following cycle.
- `cpu_reset` stays high for exactly 1+RESET_CYCLES sampled edges from the edge that sees `reset`=0.

## Configuration
- `RUN_MONITOR_LOG_EN` defined: a circular write log of LOG_DEPTH entries is built.
  - The write pointer wraps modulo LOG_DEPTH.
  - `log_idx`=k returns the (k+1)-th newest write.
  - Unwritten entries read 0.
- Not defined: no log storage is built. Ports remain, and `log_adr`/`log_data` are tied to 0.

## Structure
- Package `run_monitor_pkg`: state enum `run_state_t`, default PASS_ADR/PASS_DATA constants.
- Sub-module `write_log`: circular buffer with write pointer and indexed newest-relative read. It is instantiated only under `RUN_MONITOR_LOG_EN`.

## Test plan
- Reset sequence: `reset`=1 for 1 cycle, RESET_CYCLES=2 → `cpu_reset` high for 3 edges, then 0; `cycle_count` starts at 0.
- Pass path: writes (80,5) then (84,7) in RUN → `pass`=`done`=1 the cycle after the second write; `write_count`=2; `last_adr`=84; `cpu_reset`=1.
- Wrong data: write (84,6) → `fail`=1, `timeout`=0.
- Timeout: TIMEOUT=20, no writes → `fail`=`timeout`=1 with `cycle_count`=19. Same setup with (84,7) on cycle 19 → `pass`=1.
- Log wrap (with `RUN_MONITOR_LOG_EN`): 10 writes to addresses 0..9, LOG_DEPTH=8 → `log_idx`=0 reads 9, `log_idx`=7 reads 2. Without the macro → 0.
- Mid-run reset: `reset` pulsed in RUN after 5 writes → counters and log clear; the block returns to HOLD.

Source files
------------

// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared types and default constants for the run monitor.
//   run_state_t   - controller state (HOLD -> RUN -> PASS | FAIL)
//   DEF_PASS_ADR  - default address whose write decides the verdict
//   DEF_PASS_DATA - default data value that means pass
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } run_state_t;

  localparam int unsigned DEF_PASS_ADR  = 84;
  localparam int unsigned DEF_PASS_DATA = 7;

endpackage

// File: rtl/write_log.sv
// write_log: circular buffer of the most recent processor writes.
//   clk, reset          - clock and synchronous active-high clear
//   wr_en               - store (wr_adr, wr_data) at the write pointer
//   rd_idx              - newest-relative read index (0 = newest)
//   rd_adr, rd_data     - combinational read of the selected entry
// DEPTH must be a power of two so the pointer wraps by plain overflow.
module write_log #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_adr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_adr,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] adr_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  rd_ptr;

  // NOTE: the storage is cleared on reset on purpose: entries never written
  // since reset must read 0, so this cannot be a plain reset-less RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        adr_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else if (wr_en) begin
      adr_mem[wr_ptr]  <= wr_adr;
      data_mem[wr_ptr] <= wr_data;
      wr_ptr           <= wr_ptr + 1'b1;
    end
  end

  // wr_ptr points at the next free slot, so the newest entry is one behind.
  assign rd_ptr  = wr_ptr - IDX_W'(1) - rd_idx;
  assign rd_adr  = adr_mem[rd_ptr];
  assign rd_data = data_mem[rd_ptr];

endmodule

// File: rtl/run_monitor.sv
// run_monitor: processor reset sequencer, cycle counter and write monitor
// that declares pass, fail or timeout from the data-memory write port.
//   clk, reset              - clock, synchronous active-high reset
//   cpu_reset               - reset to the processor (high in HOLD/PASS/FAIL)
//   memwrite/dataadr/writedata - observed processor write port
//   done/pass/fail/timeout  - sticky verdict flags
//   cycle_count/write_count - RUN cycles and RUN writes, saturating
//   last_adr/last_data      - most recent RUN write
//   log_idx -> log_adr/log_data - write history read (0 = newest)
// Optional build macro: RUN_MONITOR_LOG_EN builds the write log; without it
// the log ports read 0.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned PASS_ADR     = DEF_PASS_ADR,
  parameter int unsigned PASS_DATA    = DEF_PASS_DATA,
  parameter int unsigned LOG_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         cpu_reset,
  input  logic                         memwrite,
  input  logic [DATA_W-1:0]            dataadr,
  input  logic [DATA_W-1:0]            writedata,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic [CNT_W-1:0]             cycle_count,
  output logic [CNT_W-1:0]             write_count,
  output logic [DATA_W-1:0]            last_adr,
  output logic [DATA_W-1:0]            last_data,
  input  logic [$clog2(LOG_DEPTH)-1:0] log_idx,
  output logic [DATA_W-1:0]            log_adr,
  output logic [DATA_W-1:0]            log_data
);

  // Hold counter must be at least one bit wide even when RESET_CYCLES = 0.
  localparam int unsigned HOLD_W = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;

  run_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              run_write;
  logic              decide_write;

  assign run_write    = (state == ST_RUN) && memwrite;
  assign decide_write = run_write && (dataadr == DATA_W'(PASS_ADR));

  // NOTE: every register here is assigned with <= so all updates take the
  // values sampled at the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_HOLD;
      hold_cnt    <= '0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      write_count <= '0;
      last_adr    <= '0;
      last_data   <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          // The edge that sees hold_cnt == RESET_CYCLES is the last HOLD edge,
          // giving 1+RESET_CYCLES edges of cpu_reset after reset falls.
          if (hold_cnt == HOLD_W'(RESET_CYCLES)) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (run_write) begin
            if (~&write_count) write_count <= write_count + 1'b1;
            last_adr  <= dataadr;
            last_data <= writedata;
          end
          // A deciding write outranks the timeout; cycle_count freezes on
          // the edge that reaches a verdict.
          if (decide_write) begin
            done      <= 1'b1;
            cpu_reset <= 1'b1;
            if (writedata == DATA_W'(PASS_DATA)) begin
              pass  <= 1'b1;
              state <= ST_PASS;
            end else begin
              fail  <= 1'b1;
              state <= ST_FAIL;
            end
          end else if (cycle_count == CNT_W'(TIMEOUT - 1)) begin
            done      <= 1'b1;
            fail      <= 1'b1;
            timeout   <= 1'b1;
            cpu_reset <= 1'b1;
            state     <= ST_FAIL;
          end else if (~&cycle_count) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end

        default: ; // PASS/FAIL are terminal until reset
      endcase
    end
  end

`ifdef RUN_MONITOR_LOG_EN
  write_log #(
    .DATA_W (DATA_W),
    .DEPTH  (LOG_DEPTH)
  ) u_write_log (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (run_write),
    .wr_adr  (dataadr),
    .wr_data (writedata),
    .rd_idx  (log_idx),
    .rd_adr  (log_adr),
    .rd_data (log_data)
  );
`else
  logic unused_log_idx;
  assign unused_log_idx = ^log_idx;
  assign log_adr        = '0;
  assign log_data       = '0;
`endif

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed and randomized checks of run_monitor against a
// behavioural model that tracks edges since reset, verdict flags and a queue
// of recent writes.
module tb_run_monitor;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int RC     = 2;
  localparam int TO     = 20;
  localparam int PA     = 84;
  localparam int PD     = 7;
  localparam int LD     = 8;
  localparam int LW     = $clog2(LD);

  logic              clk;
  logic              reset;
  logic              cpu_reset;
  logic              memwrite;
  logic [DATA_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;
  logic              done, pass, fail, timeout;
  logic [CNT_W-1:0]  cycle_count, write_count;
  logic [DATA_W-1:0] last_adr, last_data;
  logic [LW-1:0]     log_idx;
  logic [DATA_W-1:0] log_adr, log_data;

  run_monitor #(
    .DATA_W (DATA_W), .CNT_W (CNT_W), .RESET_CYCLES (RC), .TIMEOUT (TO),
    .PASS_ADR (PA), .PASS_DATA (PD), .LOG_DEPTH (LD)
  ) dut (
    .clk (clk), .reset (reset), .cpu_reset (cpu_reset),
    .memwrite (memwrite), .dataadr (dataadr), .writedata (writedata),
    .done (done), .pass (pass), .fail (fail), .timeout (timeout),
    .cycle_count (cycle_count), .write_count (write_count),
    .last_adr (last_adr), .last_data (last_data),
    .log_idx (log_idx), .log_adr (log_adr), .log_data (log_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  int          m_low;    // non-reset edges seen since reset (capped)
  bit          m_done, m_pass, m_fail, m_to;
  int          m_cyc, m_wc;
  logic [31:0] m_ladr, m_ldata;
  wr_t         m_log[$];

  int tests = 0;
  int fails = 0;

  task automatic model_clear();
    m_low = 0; m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
    m_cyc = 0; m_wc = 0; m_ladr = 0; m_ldata = 0;
    m_log.delete();
  endtask

  task automatic model_edge(input bit r, input bit mw, input logic [31:0] a, input logic [31:0] d);
    if (r) begin
      model_clear();
    end else if (!m_done) begin
      if (m_low > RC) begin
        if (mw) begin
          if (m_wc < 65535) m_wc++;
          m_ladr  = a;
          m_ldata = d;
          m_log.push_front('{a: a, d: d});
          if (m_log.size() > LD) void'(m_log.pop_back());
        end
        if (mw && a == PA) begin
          m_done = 1; m_pass = (d == PD); m_fail = (d != PD);
        end else if (m_cyc == TO - 1) begin
          m_done = 1; m_fail = 1; m_to = 1;
        end else begin
          m_cyc++;
        end
      end else begin
        m_low++;
      end
    end
  endtask

  function automatic logic [31:0] exp_log_adr(input int k);
`ifdef RUN_MONITOR_LOG_EN
    return (k < m_log.size()) ? m_log[k].a : 32'd0;
`else
    return (k < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_log_data(input int k);
`ifdef RUN_MONITOR_LOG_EN
    return (k < m_log.size()) ? m_log[k].d : 32'd0;
`else
    return (k < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("cpu_reset",   32'(cpu_reset),   32'(m_done || !(m_low > RC)));
    check("done",        32'(done),        32'(m_done));
    check("pass",        32'(pass),        32'(m_pass));
    check("fail",        32'(fail),        32'(m_fail));
    check("timeout",     32'(timeout),     32'(m_to));
    check("cycle_count", 32'(cycle_count), m_cyc);
    check("write_count", 32'(write_count), m_wc);
    check("last_adr",    last_adr,         m_ladr);
    check("last_data",   last_data,        m_ldata);
    check("log_adr",     log_adr,          exp_log_adr(int'(log_idx)));
    check("log_data",    log_data,         exp_log_data(int'(log_idx)));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare 1 time unit later.
  task automatic step(input bit r, input bit mw, input logic [31:0] a, input logic [31:0] d);
    reset     = r;
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    log_idx   = LW'($urandom_range(LD - 1));
    @(posedge clk);
    model_edge(r, mw, a, d);
    #1;
    check_all();
  endtask

  task automatic scan_log();
    for (int k = 0; k < LD; k++) begin
      log_idx = LW'(k);
      #1;
      check("scan_adr",  log_adr,  exp_log_adr(k));
      check("scan_data", log_data, exp_log_data(k));
    end
  endtask

  task automatic to_run();
    step(1, 0, 0, 0);
    repeat (RC + 1) step(0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; log_idx = '0;
    model_clear();

    // Reset state and reset sequence; a passing write during HOLD is ignored.
    step(1, 0, 0, 0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_cycles",    32'(cycle_count), 32'd0);
    step(0, 1, PA, PD);
    step(0, 0, 0, 0);
    step(0, 1, PA, PD);
    check("seq_cpu_low",   32'(cpu_reset), 32'd0);
    check("seq_no_pass",   32'(pass),      32'd0);
    check("seq_cyc0",      32'(cycle_count), 32'd0);

    // Pass path, then writes after the verdict are ignored.
    step(0, 1, 80, 5);
    step(0, 1, PA, PD);
    check("pp_pass",  32'(pass),        32'd1);
    check("pp_done",  32'(done),        32'd1);
    check("pp_wc",    32'(write_count), 32'd2);
    check("pp_adr",   last_adr,         32'd84);
    check("pp_cpu",   32'(cpu_reset),   32'd1);
    step(0, 1, 3, 3);
    step(0, 0, 0, 0);
    scan_log();

    // Wrong data at the pass address.
    to_run();
    step(0, 1, PA, 6);
    check("wd_fail", 32'(fail),    32'd1);
    check("wd_to",   32'(timeout), 32'd0);

    // Timeout with no writes.
    to_run();
    for (int i = 0; i < 40 && !m_done; i++) step(0, 0, 0, 0);
    check("to_done",  32'(done),        32'd1);
    check("to_flag",  32'(timeout),     32'd1);
    check("to_cycle", 32'(cycle_count), 32'd19);

    // Deciding write on the timeout cycle wins.
    to_run();
    for (int i = 0; i < 40 && m_cyc < TO - 1; i++) step(0, 0, 0, 0);
    step(0, 1, PA, PD);
    check("tp_pass", 32'(pass),    32'd1);
    check("tp_to",   32'(timeout), 32'd0);

    // Log wrap: ten writes to addresses 0..9.
    to_run();
    for (int i = 0; i < 10; i++) step(0, 1, i, 100 + i);
    scan_log();
    log_idx = LW'(0); #1;
`ifdef RUN_MONITOR_LOG_EN
    check("wrap_newest", log_adr, 32'd9);
`else
    check("wrap_newest", log_adr, 32'd0);
`endif
    log_idx = LW'(7); #1;
`ifdef RUN_MONITOR_LOG_EN
    check("wrap_oldest", log_adr, 32'd2);
`else
    check("wrap_oldest", log_adr, 32'd0);
`endif

    // Mid-run reset after five writes.
    to_run();
    for (int i = 0; i < 5; i++) step(0, 1, 10 + i, i);
    step(1, 0, 0, 0);
    check("mr_wc",  32'(write_count), 32'd0);
    check("mr_adr", last_adr,         32'd0);
    check("mr_cpu", 32'(cpu_reset),   32'd1);
    scan_log();
    step(0, 0, 0, 0);
    check("mr_hold", 32'(cpu_reset), 32'd1);

    // Randomized episodes, including occasional resets mid-episode.
    for (int e = 0; e < 25; e++) begin
      int len;
      step(1, 0, 0, 0);
      len = $urandom_range(40, 5);
      for (int s = 0; s < len; s++) begin
        bit          r, mw;
        logic [31:0] a, d;
        r  = ($urandom_range(99) < 3);
        mw = $urandom_range(1);
        a  = ($urandom_range(7) == 0) ? 32'(PA) : 32'($urandom_range(127));
        d  = ($urandom_range(1) == 1) ? 32'(PD) : 32'($urandom_range(15));
        step(r, mw, a, d);
      end
      scan_log();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
